// File: rtl/triple_vote_sequencer.sv
// Collects three vote bits per round and emits majority/unanimity flags
// through valid/ready handshakes, counting delivered majority rounds.
module triple_vote_sequencer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic             in_bit,
  output logic             out_val,
  input  logic             out_rdy,
  output logic             out_maj,
  output logic             out_tri,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {
    COLLECT,
    SEND
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t     state;
  state_t     state_nxt;
  logic [1:0] idx;
  logic [2:0] vote;
  logic       in_hs;
  logic       out_hs;
  logic       last;

  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_rdy    = 1'b0;
    out_val   = 1'b0;
    unique case (state)
      COLLECT: begin
        in_rdy = 1'b1;
        if (in_val && idx == 2'd2) state_nxt = SEND;
      end
      SEND: begin
        out_val = 1'b1;
        if (out_rdy) state_nxt = COLLECT;
      end
    endcase
    in_hs  = in_val && in_rdy;
    out_hs = out_val && out_rdy;
    last   = idx == 2'd2;
  end

  // Result flags are registered so outputs never depend on in_* directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= 2'd0;
      vote    <= 3'b000;
      out_maj <= 1'b0;
      out_tri <= 1'b0;
    end else if (in_hs) begin
      vote[idx] <= in_bit;
      if (last) begin
        idx     <= 2'd0;
        out_maj <= (vote[0] & vote[1]) | (vote[0] & in_bit)
                 | (vote[1] & in_bit);
        out_tri <= vote[0] & vote[1] & in_bit;
      end else begin
        idx <= idx + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (out_hs && out_maj && count != CNT_MAX) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_triple_vote_sequencer.sv
// Directed table-driven bench for triple_vote_sequencer, plus hand
// sequences for counter saturation and clear/handshake collisions.
module tb_triple_vote_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_val = 1'b0;
  logic       in_bit = 1'b0;
  logic       out_rdy = 1'b0;
  logic       clr = 1'b0;
  logic       in_rdy, out_val, out_maj, out_tri;
  logic [7:0] count;
  logic       in_rdy2, out_val2, out_maj2, out_tri2;
  logic [1:0] count2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  triple_vote_sequencer #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy), .in_bit(in_bit),
    .out_val(out_val), .out_rdy(out_rdy),
    .out_maj(out_maj), .out_tri(out_tri),
    .clr(clr), .count(count)
  );

  triple_vote_sequencer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .in_val(in_val), .in_rdy(in_rdy2), .in_bit(in_bit),
    .out_val(out_val2), .out_rdy(out_rdy),
    .out_maj(out_maj2), .out_tri(out_tri2),
    .clr(clr), .count(count2)
  );

  typedef struct {
    logic       rst, iv, ib, ordy, clr;
    logic       rdy, val, maj, tr;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[35];

  task automatic chk(input string nm, input int i,
                     input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @%0d: got %0d want %0d", nm, i, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic iv, input logic ib,
                      input logic ordy, input logic c);
    rst = r; in_val = iv; in_bit = ib; out_rdy = ordy; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_round(input int i, input logic b0, input logic b1,
                          input logic b2, input logic c);
    step(0, 1, b0, 0, 0);
    step(0, 1, b1, 0, 0);
    step(0, 1, b2, 0, 0);
    chk("round_val", i, {7'd0, out_val}, 8'd1);
    step(0, 0, 0, 1, c);
    chk("round_rdy", i, {7'd0, in_rdy}, 8'd1);
  endtask

  initial begin
    // rst iv ib ordy clr | rdy val maj tri cnt
    tbl[0]  = '{1,0,0,0,0, 1,0,0,0,0};
    tbl[1]  = '{0,1,1,0,0, 1,0,0,0,0};
    tbl[2]  = '{0,1,0,0,0, 1,0,0,0,0};
    tbl[3]  = '{0,1,1,0,0, 0,1,1,0,0};
    tbl[4]  = '{0,1,0,0,0, 0,1,1,0,0};
    tbl[5]  = '{0,1,0,0,0, 0,1,1,0,0};
    tbl[6]  = '{0,1,0,0,0, 0,1,1,0,0};
    tbl[7]  = '{0,0,0,1,0, 1,0,1,0,1};
    tbl[8]  = '{0,1,1,1,0, 1,0,1,0,1};
    tbl[9]  = '{0,1,1,1,0, 1,0,1,0,1};
    tbl[10] = '{0,1,1,1,0, 0,1,1,1,1};
    tbl[11] = '{0,1,0,1,0, 1,0,1,1,2};
    tbl[12] = '{0,1,0,1,0, 1,0,1,1,2};
    tbl[13] = '{0,1,0,1,0, 1,0,1,1,2};
    tbl[14] = '{0,1,1,1,0, 0,1,0,0,2};
    tbl[15] = '{0,0,0,1,0, 1,0,0,0,2};
    tbl[16] = '{0,1,0,0,0, 1,0,0,0,2};
    tbl[17] = '{0,0,1,0,0, 1,0,0,0,2};
    tbl[18] = '{0,0,0,0,0, 1,0,0,0,2};
    tbl[19] = '{0,1,1,0,0, 1,0,0,0,2};
    tbl[20] = '{0,0,0,0,0, 1,0,0,0,2};
    tbl[21] = '{0,0,1,0,0, 1,0,0,0,2};
    tbl[22] = '{0,1,1,0,0, 0,1,1,0,2};
    tbl[23] = '{0,0,0,1,0, 1,0,1,0,3};
    tbl[24] = '{0,1,1,0,0, 1,0,1,0,3};
    tbl[25] = '{0,1,1,0,0, 1,0,1,0,3};
    tbl[26] = '{1,0,0,0,0, 1,0,0,0,0};
    tbl[27] = '{0,1,0,0,0, 1,0,0,0,0};
    tbl[28] = '{0,1,0,0,0, 1,0,0,0,0};
    tbl[29] = '{0,1,1,0,0, 0,1,0,0,0};
    tbl[30] = '{0,0,0,1,0, 1,0,0,0,0};
    tbl[31] = '{0,1,1,0,0, 1,0,0,0,0};
    tbl[32] = '{0,1,1,0,0, 1,0,0,0,0};
    tbl[33] = '{0,1,1,0,0, 0,1,1,1,0};
    tbl[34] = '{1,0,0,1,1, 1,0,0,0,0};

    #1;
    for (int i = 0; i < 35; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].ib, tbl[i].ordy, tbl[i].clr);
      chk("in_rdy",  i, {7'd0, in_rdy},  {7'd0, tbl[i].rdy});
      chk("out_val", i, {7'd0, out_val}, {7'd0, tbl[i].val});
      chk("out_maj", i, {7'd0, out_maj}, {7'd0, tbl[i].maj});
      chk("out_tri", i, {7'd0, out_tri}, {7'd0, tbl[i].tr});
      chk("count",   i, count,           tbl[i].cnt);
    end

    // Saturation of the 2-bit counter alongside the 8-bit one.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      do_round(100 + i, 1, 1, 0, 0);
      chk("cnt8", 100 + i, count, 8'(i + 1));
      chk("cnt2", 100 + i, {6'd0, count2}, (i < 3) ? 8'(i + 1) : 8'd3);
    end

    // Clear wins over a coinciding incrementing handshake.
    do_round(200, 1, 0, 1, 1);
    chk("clr_win", 200, count, 8'd0);
    chk("clr_st", 200, {7'd0, out_val}, 8'd0);

    // Clear mid-collection leaves votes and index untouched.
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 0);
    chk("clr_val", 300, {7'd0, out_val}, 8'd1);
    chk("clr_tri", 300, {7'd0, out_tri}, 8'd1);
    step(0, 0, 0, 1, 0);
    chk("clr_cnt", 300, count, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/triple_vote_sequencer.md
TRIPLE_VOTE_SEQUENCER -- requirements
Module: triple_vote_sequencer

Interface
REQ-001 The block SHALL have a parameter CNT_W, default 8, giving the width of the round-result counter; the legal range is 1 to 16.
REQ-002 The block SHALL have an input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have an input rst, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have an input in_val, 1 bit: the upstream vote bit is valid.
REQ-005 The block SHALL have an output in_rdy, 1 bit: the block can accept a vote bit.
REQ-006 The block SHALL have an input in_bit, 1 bit: the vote bit; it is sampled only on an input handshake (in_val && in_rdy).
REQ-007 The block SHALL have an output out_val, 1 bit: a round result is valid.
REQ-008 The block SHALL have an input out_rdy, 1 bit: downstream accepts the result.
REQ-009 The block SHALL have an output out_maj, 1 bit: at least two of the three round votes are 1 (pair/triple).
REQ-010 The block SHALL have an output out_tri, 1 bit: all three round votes are 1.
REQ-011 The block SHALL have an input clr, 1 bit: synchronous clear of count only.
REQ-012 The block SHALL have an output count, CNT_W bits: a saturating count of delivered rounds with out_maj=1.

Function
REQ-013 The block SHALL implement a two-state FSM: COLLECT and SEND.
REQ-014 In COLLECT, the block SHALL drive in_rdy=1 and out_val=0; in SEND, it SHALL drive in_rdy=0 and out_val=1.
REQ-015 The block SHALL keep a 2-bit index idx (values 0 to 2); each input handshake SHALL store in_bit into vote[idx] and increment idx.
REQ-016 A handshake with idx==2 SHALL set idx to 0 and transition to SEND.
REQ-017 On that same edge, the block SHALL register out_maj = majority(vote0, vote1, in_bit) and out_tri = AND(vote0, vote1, in_bit).
REQ-018 Latency: out_val SHALL rise exactly one cycle after the third input handshake; there SHALL be no combinational path from in_* to out_*.
REQ-019 Cycles with in_val=0 SHALL NOT change idx or vote; in_bit is don't-care in those cycles.
REQ-020 In SEND, out_maj and out_tri SHALL hold stable while out_rdy=0, for any number of cycles.
REQ-021 An output handshake (out_val && out_rdy) SHALL return the FSM to COLLECT on that edge.
REQ-022 in_rdy SHALL be 1 on the cycle after the output handshake, with no bypass: an input offered during SEND is not accepted.
REQ-023 On an output handshake with out_maj=1, count SHALL increment by 1, visible the next cycle.
REQ-024 count SHALL saturate at 2^CNT_W-1 and SHALL never wrap.
REQ-025 clr=1 SHALL set count to 0 on the next edge.
REQ-026 If clr=1 and an incrementing output handshake coincide, clr SHALL win (count becomes 0), while the FSM still returns to COLLECT.
REQ-027 clr SHALL NOT affect the FSM state, idx, vote, out_maj or out_tri.
REQ-028 out_maj and out_tri SHALL retain their last values in COLLECT, but they are meaningful only while out_val=1.

Reset
REQ-029 When rst=1 at a rising edge, the block SHALL set: state=COLLECT, idx=0, vote=0, out_val=0, out_maj=0, out_tri=0, count=0, in_rdy=1.
REQ-030 rst SHALL take priority over every other input, including clr and simultaneous handshakes.
REQ-031 A reset mid-collection SHALL discard partial votes; a reset during SEND SHALL drop the pending result without incrementing count.

Verification
REQ-032 Reset, then votes 1,0,1 on consecutive cycles -> out_val=1 on the next cycle with out_maj=1, out_tri=0; hold out_rdy=0 for 3 cycles -> outputs stable and in_rdy=0; then out_rdy=1 -> count=1 and in_rdy=1.
REQ-033 Votes 1,1,1 then 0,0,1 with out_rdy=1 -> first result out_maj=1, out_tri=1; second result out_maj=0, out_tri=0; count increases by exactly 1.
REQ-034 Votes 0,1,1 with in_val=0 idle gaps of 2 cycles and in_bit toggling during the gaps -> out_maj=1, out_tri=0; the gap values are ignored.
REQ-035 With CNT_W=2, five majority rounds -> count reads 1,2,3,3,3.
REQ-036 With count=5 and clr=1 on the same cycle as an out_maj=1 output handshake -> count=0 and state=COLLECT.
REQ-037 Accept votes 1,1, assert rst for one cycle, then send votes 0,0,1 -> single result out_maj=0, and count remains 0.
